memory_access_stage: RTL and testbench
======================================

Name: memory_access_stage

Overview:
- Pipeline stage between execute and write-back.
- Consumes a MemoryAccessStagePipeReg plus a valid bit, performs loads and stores over a req/ack data-memory port, and registers a WriteBackStagePipeReg plus a valid bit for write-back.
- Generates the pipeline stall while a memory access is outstanding.
- Non-memory instructions pass through with one-cycle latency.

Parameters:
- DATA_WIDTH, 32, data/word width; fixed 32 in this revision, 4 byte lanes.
- ADDR_WIDTH, 32, width of dmem_addr.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  in_pipe holds a live instruction
- in_pipe  in  MemoryAccessStagePipeReg  instruction from execute
- stall  out  1  upstream must hold in_pipe/in_valid this cycle
- out_valid  out  1  out_pipe live (registered)
- out_pipe  out  WriteBackStagePipeReg  result to write-back (registered)
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = store
- dmem_addr  out  ADDR_WIDTH  word-aligned address {aluResult[31:2],2'b00}
- dmem_wdata  out  32  lane-replicated store data
- dmem_be  out  4  byte enables (0 for loads)
- dmem_ack  in  1  access complete; load data valid on dmem_rdata this cycle
- dmem_rdata  in  32  load word
- misaligned  out  1  registered with out_valid; only with MISALIGN_TRAP_EN, else tied 0

Behaviour:
- Reset (rst=0, async): state=IDLE, out_valid=0, out_pipe=0, misaligned=0. dmem_req is 0 because it derives from in_valid/state.
- mem_op = in_valid & (isLoad | isStore).
- FSM states: IDLE, WAIT.
  - dmem_req = mem_op in IDLE, or 1 in WAIT (combinational).
  - IDLE -> WAIT when dmem_req & !dmem_ack.
  - WAIT -> IDLE on dmem_ack.
  - Zero-wait memory (ack in the same cycle as req) never enters WAIT.
- stall = dmem_req & !dmem_ack. In_pipe is stable during the stall, so dmem_* stays stable until ack.
- Width encoding (memAccessWidth): 00 byte, 01 half, 10/11 word. off = aluResult[1:0].
- Store lanes and data:
  - byte: be = 4'b0001 << off; wdata = {4{wData[7:0]}}.
  - half: be = off[1] ? 4'b1100 : 4'b0011; wdata = {2{wData[15:0]}}.
  - word: be = 4'b1111; wdata = wData.
- Load extract:
  - byte: lane off.
  - half: lane pair off[1].
  - word: full word.
  - Sign-extended unless isLoadUnsigned, in which case zero-extended.
- Registered at posedge when an instruction completes, i.e. (in_valid & !mem_op) or (dmem_req & dmem_ack):
  - out_valid = 1.
  - out_pipe.pc/alu_result/rdCtrl copied from in_pipe.
  - is_load = isLoad.
  - r_data = extracted load value; 0 for non-loads.
- In any other cycle out_valid = 0, i.e. a bubble is inserted; out_pipe contents are don't-care but hold previous values.
- Stores complete with r_data = 0. rdCtrl is passed unchanged; decode guarantees write-enable is cleared for stores.
- Back-to-back memory ops: a new req may be asserted in the cycle after an ack.
- dmem_ack while dmem_req = 0 is ignored.
- Reset asserted mid-WAIT aborts the access immediately: req drops and any later ack is ignored.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- When defined:
  - A half access with off[0]=1, or a word access with off != 0, is misaligned.
  - No dmem_req is issued; the access completes in one cycle.
  - out_valid=1, misaligned=1, out_pipe.rdCtrl.wEnable cleared, r_data=0.
- When undefined:
  - No check; low offset bits beyond lane selection are ignored (half uses off[1], word uses none).
  - misaligned is tied 0.

Test Plan:
- Non-mem op, in_valid=1, aluResult=0x1234 -> next cycle out_valid=1, alu_result=0x1234, stall never asserted, dmem_req=0.
- Load byte signed at addr 0x103, dmem_rdata=0x80FF_0000, ack same cycle -> dmem_addr=0x100, be=0; out r_data=0xFFFF_FF80, is_load=1, no stall.
- Store half wData=0xABCD at addr 0x202, ack after 3 cycles -> stall high 3 cycles, be=4'b1100, wdata=0xABCD_ABCD stable throughout; out_valid only in the cycle after ack.
- Load half unsigned at 0x6, rdata=0x8001_0000, ack 1 cycle late -> r_data=0x0000_8001. Back-to-back load word immediately follows -> req asserted the cycle after ack.
- Reset pulse while in WAIT -> out_valid=0, dmem_req=0 during reset; post-reset ack is ignored and no out_valid is produced.
- With MISALIGN_TRAP_EN, load word at 0x102 -> no dmem_req; next cycle out_valid=1, misaligned=1, rdCtrl.wEnable=0. Without the macro -> normal access at 0x100.

Source files
------------

// File: rtl/memory_access_stage_if.sv
// Pipeline register types and the bus interface for the memory access stage.
// master = the stage itself, slave = the surrounding pipeline and data memory.
package memory_access_stage_pkg;
    typedef struct packed {
        logic       wEnable;
        logic [4:0] wAddr;
    } RdCtrl;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] aluResult;
        logic [31:0] wData;
        logic        isLoad;
        logic        isStore;
        logic        isLoadUnsigned;
        logic [1:0]  memAccessWidth;
        RdCtrl       rdCtrl;
    } MemoryAccessStagePipeReg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] alu_result;
        logic [31:0] r_data;
        logic        is_load;
        RdCtrl       rdCtrl;
    } WriteBackStagePipeReg;
endpackage

interface memory_access_stage_if #(parameter int ADDR_WIDTH = 32);
    import memory_access_stage_pkg::*;

    logic                    in_valid;
    MemoryAccessStagePipeReg in_pipe;
    logic                    stall;
    logic                    out_valid;
    WriteBackStagePipeReg    out_pipe;
    logic                    dmem_req;
    logic                    dmem_we;
    logic [ADDR_WIDTH-1:0]   dmem_addr;
    logic [31:0]             dmem_wdata;
    logic [3:0]              dmem_be;
    logic                    dmem_ack;
    logic [31:0]             dmem_rdata;
    logic                    misaligned;

    modport master (
        input  in_valid, in_pipe, dmem_ack, dmem_rdata,
        output stall, out_valid, out_pipe, dmem_req, dmem_we, dmem_addr,
               dmem_wdata, dmem_be, misaligned
    );

    modport slave (
        output in_valid, in_pipe, dmem_ack, dmem_rdata,
        input  stall, out_valid, out_pipe, dmem_req, dmem_we, dmem_addr,
               dmem_wdata, dmem_be, misaligned
    );
endinterface

// File: rtl/memory_access_stage.sv
// Memory access pipeline stage: loads/stores over a req/ack port, stall generation.
// Optional MISALIGN_TRAP_EN: misaligned half/word accesses complete without a request.
//
// state  | meaning
// IDLE   | no access outstanding; req follows a live memory op
// WAIT   | request issued, holding req until dmem_ack
module memory_access_stage
    import memory_access_stage_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    memory_access_stage_if.master bus
);
    typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    r_out_valid;
    WriteBackStagePipeReg    r_out_pipe;
    logic                    r_misaligned;

    MemoryAccessStagePipeReg w_in;
    logic [1:0]              w_off;
    logic                    w_mem_op;
    logic                    w_misal;
    logic                    w_issue;
    logic                    w_req;
    logic                    w_done;
    logic [3:0]              w_be_st;
    logic [DATA_WIDTH-1:0]   w_wdata;
    logic [7:0]              w_byte;
    logic [15:0]             w_half;
    logic [DATA_WIDTH-1:0]   w_load;
    logic [31:0]             w_addr;
    WriteBackStagePipeReg    w_wb;

    assign w_in     = bus.in_pipe;
    assign w_off    = w_in.aluResult[1:0];
    assign w_mem_op = bus.in_valid & (w_in.isLoad | w_in.isStore);

`ifdef MISALIGN_TRAP_EN
    assign w_misal = w_mem_op &
                     (((w_in.memAccessWidth == 2'b01) & w_off[0]) |
                      (w_in.memAccessWidth[1] & (w_off != 2'b00)));
`else
    assign w_misal = 1'b0;
`endif

    assign w_issue = w_mem_op & ~w_misal;

    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_req = w_issue;
                if (w_issue & ~bus.dmem_ack) w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                w_req = 1'b1;
                if (bus.dmem_ack) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_be_st = 4'b1111;
        w_wdata = w_in.wData;
        case (w_in.memAccessWidth)
            2'b00: begin
                w_be_st = 4'b0001 << w_off;
                w_wdata = {4{w_in.wData[7:0]}};
            end
            2'b01: begin
                w_be_st = w_off[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{w_in.wData[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        w_byte = bus.dmem_rdata[{w_off, 3'b000} +: 8];
        w_half = w_off[1] ? bus.dmem_rdata[31:16] : bus.dmem_rdata[15:0];
        case (w_in.memAccessWidth)
            2'b00:   w_load = {{24{~w_in.isLoadUnsigned & w_byte[7]}}, w_byte};
            2'b01:   w_load = {{16{~w_in.isLoadUnsigned & w_half[15]}}, w_half};
            default: w_load = bus.dmem_rdata;
        endcase
    end

    // Trapped accesses complete immediately and must not write the register file.
    always_comb begin
        w_wb            = '0;
        w_wb.pc         = w_in.pc;
        w_wb.alu_result = w_in.aluResult;
        w_wb.rdCtrl     = w_in.rdCtrl;
        w_wb.is_load    = w_in.isLoad;
        w_wb.r_data     = (w_in.isLoad & ~w_misal) ? w_load : '0;
        if (w_misal) w_wb.rdCtrl.wEnable = 1'b0;
    end

    assign w_done = (bus.in_valid & ~w_mem_op) | (w_req & bus.dmem_ack) | w_misal;
    assign w_addr = {w_in.aluResult[31:2], 2'b00};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_out_valid  <= 1'b0;
            r_out_pipe   <= '0;
            r_misaligned <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_out_valid  <= w_done;
            r_misaligned <= w_misal;
            if (w_done) r_out_pipe <= w_wb;
        end
    end

    assign bus.stall      = w_req & ~bus.dmem_ack;
    assign bus.dmem_req   = w_req;
    assign bus.dmem_we    = w_req & w_in.isStore;
    assign bus.dmem_addr  = w_addr[ADDR_WIDTH-1:0];
    assign bus.dmem_wdata = w_wdata;
    assign bus.dmem_be    = (w_req & w_in.isStore) ? w_be_st : 4'b0000;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_pipe   = r_out_pipe;
`ifdef MISALIGN_TRAP_EN
    assign bus.misaligned = r_misaligned;
`else
    assign bus.misaligned = 1'b0;
`endif
endmodule

// File: tb/tb_memory_access_stage.sv
// Self-checking bench for memory_access_stage: scoreboard on write-back output
// plus per-scenario checks of the memory port and stall.
module tb_memory_access_stage;
    import memory_access_stage_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    memory_access_stage_if #(.ADDR_WIDTH(32)) bus ();

    memory_access_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        WriteBackStagePipeReg wb;
        logic                 mis;
    } exp_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb_q[$];

    function automatic logic [31:0] exp_load(input logic [1:0] w, input logic [1:0] off,
                                             input logic uns, input logic [31:0] d);
        logic [31:0] v;
        int          sh;
        case (w)
            2'b00: begin
                sh = int'(off) * 8;
                v  = (d >> sh) & 32'h0000_00FF;
                if (!uns && v[7]) v = v | 32'hFFFF_FF00;
            end
            2'b01: begin
                v = off[1] ? (d >> 16) : (d & 32'h0000_FFFF);
                if (!uns && v[15]) v = v | 32'hFFFF_0000;
            end
            default: v = d;
        endcase
        return v;
    endfunction

    function automatic MemoryAccessStagePipeReg mk(input logic ld, input logic st, input logic uns,
                                                   input logic [1:0] w, input logic [31:0] addr,
                                                   input logic [31:0] wd);
        MemoryAccessStagePipeReg p;
        p                = '0;
        p.pc             = 32'h0000_4000 + addr;
        p.aluResult      = addr;
        p.wData          = wd;
        p.isLoad         = ld;
        p.isStore        = st;
        p.isLoadUnsigned = uns;
        p.memAccessWidth = w;
        p.rdCtrl.wEnable = ~st;
        p.rdCtrl.wAddr   = 5'd7;
        return p;
    endfunction

    function automatic exp_t exp_of(input MemoryAccessStagePipeReg p, input logic [31:0] rd,
                                    input logic mis);
        exp_t e;
        e                 = '0;
        e.wb.pc           = p.pc;
        e.wb.alu_result   = p.aluResult;
        e.wb.rdCtrl       = p.rdCtrl;
        e.wb.is_load      = p.isLoad;
        e.wb.r_data       = (p.isLoad && !mis) ? exp_load(p.memAccessWidth, p.aluResult[1:0],
                                                          p.isLoadUnsigned, rd) : 32'h0;
        if (mis) e.wb.rdCtrl.wEnable = 1'b0;
        e.mis             = mis;
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst && bus.out_valid) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: out_valid=1 out_pipe=%h, required no output", bus.out_pipe);
            end else begin
                e = sb_q.pop_front();
                if ({bus.out_pipe, bus.misaligned} !== e) begin
                    n_fail++;
                    $display("FAIL sb_out: got pipe=%h mis=%b, required pipe=%h mis=%b",
                             bus.out_pipe, bus.misaligned, e.wb, e.mis);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input MemoryAccessStagePipeReg p, input logic ack, input logic [31:0] rd);
        bus.in_valid   = 1'b1;
        bus.in_pipe    = p;
        bus.dmem_ack   = ack;
        bus.dmem_rdata = rd;
    endtask

    task automatic idle();
        bus.in_valid   = 1'b0;
        bus.in_pipe    = '0;
        bus.dmem_ack   = 1'b0;
        bus.dmem_rdata = 32'h0;
    endtask

    task automatic test_reset();
        idle();
        @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.misaligned !== 1'b0 || bus.dmem_req !== 1'b0 ||
            bus.out_pipe !== '0) begin
            n_fail++;
            $display("FAIL reset: ov=%b mis=%b req=%b pipe=%h, required all 0",
                     bus.out_valid, bus.misaligned, bus.dmem_req, bus.out_pipe);
        end
        step();
        rst = 1'b1;
    endtask

    task automatic test_nonmem();
        MemoryAccessStagePipeReg p;
        p = mk(1'b0, 1'b0, 1'b0, 2'b10, 32'h0000_1234, 32'h0);
        step();
        drive(p, 1'b0, 32'h0);
        sb_q.push_back(exp_of(p, 32'h0, 1'b0));
        @(negedge clk);
        n_checks++;
        if (bus.stall !== 1'b0 || bus.dmem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL nonmem_port: stall=%b req=%b, required 0 0", bus.stall, bus.dmem_req);
        end
        step();
        idle();
        @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_pipe.alu_result !== 32'h0000_1234) begin
            n_fail++;
            $display("FAIL nonmem_out: ov=%b alu=%h, required 1 00001234",
                     bus.out_valid, bus.out_pipe.alu_result);
        end
    endtask

    task automatic test_load_byte();
        MemoryAccessStagePipeReg p;
        p = mk(1'b1, 1'b0, 1'b0, 2'b00, 32'h0000_0103, 32'h0);
        step();
        drive(p, 1'b1, 32'h80FF_0000);
        sb_q.push_back(exp_of(p, 32'h80FF_0000, 1'b0));
        @(negedge clk);
        n_checks++;
        if (bus.dmem_req !== 1'b1 || bus.dmem_we !== 1'b0 || bus.dmem_addr !== 32'h0000_0100 ||
            bus.dmem_be !== 4'b0000 || bus.stall !== 1'b0) begin
            n_fail++;
            $display("FAIL ldb_port: req=%b we=%b addr=%h be=%b stall=%b, required 1 0 00000100 0000 0",
                     bus.dmem_req, bus.dmem_we, bus.dmem_addr, bus.dmem_be, bus.stall);
        end
        step();
        idle();
        @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_pipe.r_data !== 32'hFFFF_FF80) begin
            n_fail++;
            $display("FAIL ldb_out: ov=%b r_data=%h, required 1 ffffff80",
                     bus.out_valid, bus.out_pipe.r_data);
        end
    endtask

    task automatic test_store_wait();
        MemoryAccessStagePipeReg p;
        p = mk(1'b0, 1'b1, 1'b0, 2'b01, 32'h0000_0202, 32'h0000_ABCD);
        step();
        drive(p, 1'b0, 32'h0);
        sb_q.push_back(exp_of(p, 32'h0, 1'b0));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus.stall !== 1'b1 || bus.dmem_req !== 1'b1 || bus.dmem_we !== 1'b1 ||
                bus.dmem_be !== 4'b1100 || bus.dmem_wdata !== 32'hABCD_ABCD ||
                bus.dmem_addr !== 32'h0000_0200 || bus.out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL sth_wait%0d: stall=%b req=%b we=%b be=%b wd=%h addr=%h ov=%b, required 1 1 1 1100 abcdabcd 00000200 0",
                         i, bus.stall, bus.dmem_req, bus.dmem_we, bus.dmem_be, bus.dmem_wdata,
                         bus.dmem_addr, bus.out_valid);
            end
            step();
        end
        bus.dmem_ack = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.stall !== 1'b0 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL sth_ack: stall=%b ov=%b, required 0 0", bus.stall, bus.out_valid);
        end
        step();
        idle();
        @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_pipe.r_data !== 32'h0) begin
            n_fail++;
            $display("FAIL sth_out: ov=%b r_data=%h, required 1 00000000",
                     bus.out_valid, bus.out_pipe.r_data);
        end
        p = mk(1'b0, 1'b1, 1'b0, 2'b00, 32'h0000_0301, 32'h1234_565A);
        step();
        drive(p, 1'b1, 32'h0);
        sb_q.push_back(exp_of(p, 32'h0, 1'b0));
        @(negedge clk);
        n_checks++;
        if (bus.dmem_be !== 4'b0010 || bus.dmem_wdata !== 32'h5A5A_5A5A || bus.stall !== 1'b0) begin
            n_fail++;
            $display("FAIL stb_port: be=%b wd=%h stall=%b, required 0010 5a5a5a5a 0",
                     bus.dmem_be, bus.dmem_wdata, bus.stall);
        end
        step();
        idle();
    endtask

    task automatic test_back_to_back();
        MemoryAccessStagePipeReg p1;
        MemoryAccessStagePipeReg p2;
        p1 = mk(1'b1, 1'b0, 1'b1, 2'b01, 32'h0000_0006, 32'h0);
        p2 = mk(1'b1, 1'b0, 1'b0, 2'b10, 32'h0000_0010, 32'h0);
        step();
        drive(p1, 1'b0, 32'h0);
        sb_q.push_back(exp_of(p1, 32'h8001_0000, 1'b0));
        @(negedge clk);
        n_checks++;
        if (bus.stall !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_stall: stall=%b, required 1", bus.stall);
        end
        step();
        drive(p1, 1'b1, 32'h8001_0000);
        @(negedge clk);
        n_checks++;
        if (bus.stall !== 1'b0 || bus.dmem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_ack: stall=%b req=%b, required 0 1", bus.stall, bus.dmem_req);
        end
        step();
        drive(p2, 1'b1, 32'h1234_5678);
        sb_q.push_back(exp_of(p2, 32'h1234_5678, 1'b0));
        @(negedge clk);
        n_checks++;
        if (bus.dmem_req !== 1'b1 || bus.dmem_addr !== 32'h0000_0010 || bus.out_valid !== 1'b1 ||
            bus.out_pipe.r_data !== 32'h0000_8001) begin
            n_fail++;
            $display("FAIL b2b_second: req=%b addr=%h ov=%b r_data=%h, required 1 00000010 1 00008001",
                     bus.dmem_req, bus.dmem_addr, bus.out_valid, bus.out_pipe.r_data);
        end
        step();
        idle();
        @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_pipe.r_data !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL b2b_out: ov=%b r_data=%h, required 1 12345678",
                     bus.out_valid, bus.out_pipe.r_data);
        end
    endtask

    task automatic test_reset_mid_wait();
        MemoryAccessStagePipeReg p;
        p = mk(1'b1, 1'b0, 1'b0, 2'b10, 32'h0000_0040, 32'h0);
        step();
        drive(p, 1'b0, 32'h0);
        @(negedge clk);
        n_checks++;
        if (bus.stall !== 1'b1) begin
            n_fail++;
            $display("FAIL rstw_stall: stall=%b, required 1", bus.stall);
        end
        step();
        #2;
        rst = 1'b0;
        idle();
        #1;
        n_checks++;
        if (bus.dmem_req !== 1'b0 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rstw_during: req=%b ov=%b, required 0 0", bus.dmem_req, bus.out_valid);
        end
        step();
        step();
        rst = 1'b1;
        bus.dmem_ack   = 1'b1;
        bus.dmem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        n_checks++;
        if (bus.dmem_req !== 1'b0 || bus.stall !== 1'b0) begin
            n_fail++;
            $display("FAIL rstw_lateack: req=%b stall=%b, required 0 0", bus.dmem_req, bus.stall);
        end
        step();
        idle();
        @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rstw_out: ov=%b, required 0", bus.out_valid);
        end
    endtask

    task automatic test_misalign();
        MemoryAccessStagePipeReg p;
        p = mk(1'b1, 1'b0, 1'b0, 2'b10, 32'h0000_0102, 32'h0);
        step();
`ifdef MISALIGN_TRAP_EN
        drive(p, 1'b0, 32'h0);
        sb_q.push_back(exp_of(p, 32'h0, 1'b1));
        @(negedge clk);
        n_checks++;
        if (bus.dmem_req !== 1'b0 || bus.stall !== 1'b0) begin
            n_fail++;
            $display("FAIL mis_port: req=%b stall=%b, required 0 0", bus.dmem_req, bus.stall);
        end
        step();
        idle();
        @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.misaligned !== 1'b1 || bus.out_pipe.rdCtrl.wEnable !== 1'b0) begin
            n_fail++;
            $display("FAIL mis_out: ov=%b mis=%b wen=%b, required 1 1 0",
                     bus.out_valid, bus.misaligned, bus.out_pipe.rdCtrl.wEnable);
        end
`else
        drive(p, 1'b1, 32'hDEAD_BEEF);
        sb_q.push_back(exp_of(p, 32'hDEAD_BEEF, 1'b0));
        @(negedge clk);
        n_checks++;
        if (bus.dmem_req !== 1'b1 || bus.dmem_addr !== 32'h0000_0100) begin
            n_fail++;
            $display("FAIL mis_port: req=%b addr=%h, required 1 00000100", bus.dmem_req, bus.dmem_addr);
        end
        step();
        idle();
        @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.misaligned !== 1'b0 || bus.out_pipe.r_data !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL mis_out: ov=%b mis=%b r_data=%h, required 1 0 deadbeef",
                     bus.out_valid, bus.misaligned, bus.out_pipe.r_data);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_nonmem();
        test_load_byte();
        test_store_wait();
        test_back_to_back();
        test_reset_mid_wait();
        test_misalign();
        step();
        step();
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: pending=%0d, required 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
